// File: rtl/psum_collector_pkg.sv
// Shared MAC-array geometry, lane packing helper and drain FSM encoding
// for the partial-sum collector.
package psum_collector_pkg;

  localparam int MAC_LANES = 16;
  localparam int MAC_ACC_W = 24;
  localparam int MAC_VEC_W = MAC_LANES * MAC_ACC_W;
  localparam int MAC_DEPTH = 16;
  localparam int MAC_AW    = $clog2(MAC_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } drain_state_e;

  // Bit offset of a lane inside a packed LANES*ACC_W vector.
  function automatic int lane_lsb(input int lane);
    return lane * MAC_ACC_W;
  endfunction

endpackage

// File: rtl/psum_drain_arb.sv
// Lowest-index priority select over the collector's done flags; reports the
// winning entry and whether any entry is ready to drain.
module psum_drain_arb #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic [DEPTH-1:0] done,
  output logic [AW-1:0]    sel_idx,
  output logic             any_done
);

  // Scan downward so the last hit is the lowest set index.
  always_comb begin
    sel_idx  = '0;
    any_done = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (done[i]) begin
        sel_idx  = AW'(i);
        any_done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Partial-sum collector: feeds the combinational MAC array from a register bank,
// stores its per-lane results back and drains finished vectors downstream.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int LANES = MAC_LANES,
  parameter int DEPTH = MAC_DEPTH,
  parameter int ACC_W = MAC_ACC_W,
  parameter int AW    = MAC_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [AW-1:0]          acc_addr,
  input  logic                   acc_first,
  input  logic                   acc_last,
  output logic [LANES*ACC_W-1:0] psum_out,
  input  logic [LANES*ACC_W-1:0] mac_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW-1:0]          out_addr,
  output logic [LANES*ACC_W-1:0] out_data
);

  logic [LANES*ACC_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]       done;
  drain_state_e           state;
  logic [AW-1:0]          sel_idx;
  logic                   sel_any;
  logic                   acc_fire;
  logic                   drain_fire;

  assign acc_ready  = !done[acc_addr] && !clr;
  assign acc_fire   = acc_valid && acc_ready;
  assign drain_fire = (state == VALID) && out_ready;

  // Zero-latency feed: the MAC array adds combinationally within this cycle.
  assign psum_out = (acc_valid && acc_first) ? '0 : mem[acc_addr];

  psum_drain_arb #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_arb (
    .done     (done),
    .sel_idx  (sel_idx),
    .any_done (sel_any)
  );

  // A done entry never accepts beats, so set and clear never hit the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      done <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      done <= '0;
    end else begin
      if (acc_fire) mem[acc_addr] <= mac_result;
      if (drain_fire) done[out_addr] <= 1'b0;
      if (acc_fire && acc_last) done[acc_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (clr) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            out_addr  <= sel_idx;
            out_data  <= mem[sel_idx];
            out_valid <= 1'b1;
            state     <= VALID;
          end
        end
        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
